rob_seq_ctrl: RTL and testbench

Sequencing controller for the banked reorder buffer: allocates ROB IDs to dispatched instructions and steers them round-robin into the four ROB bank FIFOs. It also records execute-stage completions and retires up to RETIRE_WIDTH completed instructions per cycle in strict program order, driving the bank read enables and the architectural-register write handshake. It sits between dispatch, the execute writeback bus and the four ROB bank FIFO instances.

---
 rtl/rob_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_rob_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rob_seq_ctrl.sv
// Sequencing controller for the banked reorder buffer: allocates ROB IDs,
// steers entries round-robin into the bank FIFOs and retires in program order.
module rob_seq_ctrl #(
    parameter int NUM_ROB_ENTS = 32,
    parameter int NUM_BANKS    = 4,
    parameter int RETIRE_WIDTH = 2,
    parameter int IDW          = $clog2(NUM_ROB_ENTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  disp_valid,
    output logic [1:0]                  disp_ready,
    output logic [2*IDW-1:0]            disp_id,
    input  logic [1:0]                  cmpl_valid,
    input  logic [2*IDW-1:0]            cmpl_id,
    input  logic                        flush,
    output logic [NUM_BANKS-1:0]        bank_w_en,
    output logic [NUM_BANKS-1:0]        bank_r_en,
    output logic                        bank_clr,
    output logic [RETIRE_WIDTH-1:0]     ret_valid,
    output logic [RETIRE_WIDTH*IDW-1:0] ret_id,
    output logic [IDW:0]                rob_count
);

    localparam int BW = $clog2(NUM_BANKS);
    localparam logic [IDW:0] FULL_CNT = (IDW+1)'(NUM_ROB_ENTS);

    // One-hot bank select from the low ID bits.
    function automatic logic [NUM_BANKS-1:0] bank_sel(input logic [IDW-1:0] id);
        bank_sel = NUM_BANKS'(1) << id[BW-1:0];
    endfunction

    logic [IDW:0]              head_r;
    logic [IDW:0]              tail_r;
    logic [IDW:0]              rob_count_r;
    logic [NUM_ROB_ENTS-1:0]   done_r;
    logic                      bank_clr_r;

    logic [IDW:0]              count_s;
    logic [IDW:0]              count_next_s;
    logic [IDW:0]              num_acc_s;
    logic [IDW:0]              num_ret_s;
    logic [1:0]                disp_ready_s;
    logic [1:0]                acc_s;
    logic [IDW-1:0]            tail_id0_s;
    logic [IDW-1:0]            tail_id1_s;
    logic [NUM_BANKS-1:0]      bank_w_en_s;
    logic [NUM_BANKS-1:0]      bank_r_en_s;
    logic [RETIRE_WIDTH-1:0]   ret_valid_s;
    logic [RETIRE_WIDTH*IDW-1:0] ret_id_s;
    logic [NUM_ROB_ENTS-1:0]   done_next_s;

    // Dispatch acceptance, ID assignment and bank write steering.
    always_comb begin
        count_s         = tail_r - head_r;
        disp_ready_s[0] = !flush && (count_s <= FULL_CNT - (IDW+1)'(1));
        disp_ready_s[1] = !flush && (count_s <= FULL_CNT - (IDW+1)'(2));
        acc_s[0]        = disp_valid[0] & disp_ready_s[0];
        acc_s[1]        = acc_s[0] & disp_valid[1] & disp_ready_s[1];
        tail_id0_s      = tail_r[IDW-1:0];
        tail_id1_s      = tail_r[IDW-1:0] + IDW'(1);
        bank_w_en_s     = (acc_s[0] ? bank_sel(tail_id0_s) : {NUM_BANKS{1'b0}})
                        | (acc_s[1] ? bank_sel(tail_id1_s) : {NUM_BANKS{1'b0}});
        num_acc_s       = (IDW+1)'(acc_s[0]) + (IDW+1)'(acc_s[1]);
    end

    // In-order retirement: each lane needs all older lanes retiring too.
    always_comb begin
        logic           chain_v;
        logic [IDW-1:0] rid_v;
        chain_v     = !flush;
        ret_valid_s = {RETIRE_WIDTH{1'b0}};
        ret_id_s    = {(RETIRE_WIDTH*IDW){1'b0}};
        bank_r_en_s = {NUM_BANKS{1'b0}};
        num_ret_s   = {(IDW+1){1'b0}};
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            rid_v                  = head_r[IDW-1:0] + IDW'(i);
            ret_id_s[i*IDW +: IDW] = rid_v;
            chain_v                = chain_v && (count_s > (IDW+1)'(i)) && done_r[rid_v];
            ret_valid_s[i]         = chain_v;
            bank_r_en_s            = bank_r_en_s | (chain_v ? bank_sel(rid_v) : {NUM_BANKS{1'b0}});
            num_ret_s              = num_ret_s + (IDW+1)'(chain_v);
        end
        count_next_s = count_s + num_acc_s - num_ret_s;
    end

    // Done-bit update: completions only land on occupied IDs, allocation clears.
    always_comb begin
        logic [IDW-1:0] eid_v;
        logic [IDW-1:0] off_v;
        logic           set_v;
        logic           clr_v;
        done_next_s = {NUM_ROB_ENTS{1'b0}};
        for (int e = 0; e < NUM_ROB_ENTS; e++) begin
            eid_v = IDW'(e);
            off_v = eid_v - head_r[IDW-1:0];
            set_v = ({1'b0, off_v} < count_s) &&
                    ((cmpl_valid[0] && (cmpl_id[IDW-1:0] == eid_v)) ||
                     (cmpl_valid[1] && (cmpl_id[2*IDW-1:IDW] == eid_v)));
            clr_v = (acc_s[0] && (tail_id0_s == eid_v)) ||
                    (acc_s[1] && (tail_id1_s == eid_v));
            done_next_s[e] = !flush && (set_v || (done_r[e] && !clr_v));
        end
    end

    // Pointer, occupancy, done and bank-clear state.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r      <= {(IDW+1){1'b0}};
            tail_r      <= {(IDW+1){1'b0}};
            rob_count_r <= {(IDW+1){1'b0}};
            done_r      <= {NUM_ROB_ENTS{1'b0}};
            bank_clr_r  <= 1'b0;
        end else if (flush) begin
            head_r      <= {(IDW+1){1'b0}};
            tail_r      <= {(IDW+1){1'b0}};
            rob_count_r <= {(IDW+1){1'b0}};
            done_r      <= {NUM_ROB_ENTS{1'b0}};
            bank_clr_r  <= 1'b1;
        end else begin
            head_r      <= head_r + num_ret_s;
            tail_r      <= tail_r + num_acc_s;
            rob_count_r <= count_next_s;
            done_r      <= done_next_s;
            bank_clr_r  <= 1'b0;
        end
    end

    assign disp_ready = disp_ready_s;
    assign disp_id    = {tail_id1_s, tail_id0_s};
    assign bank_w_en  = bank_w_en_s;
    assign bank_r_en  = bank_r_en_s;
    assign ret_valid  = ret_valid_s;
    assign ret_id     = ret_id_s;
    assign bank_clr   = bank_clr_r;
    assign rob_count  = rob_count_r;

endmodule

// File: tb/tb_rob_seq_ctrl.sv
// Directed self-checking bench for rob_seq_ctrl: fill, out-of-order completion,
// wrap-around, flush, stale completion and mid-run reset.
module tb_rob_seq_ctrl;

    localparam int IDW = 5;

    logic            clk;
    logic            rst;
    logic [1:0]      disp_valid;
    logic [1:0]      disp_ready;
    logic [2*IDW-1:0] disp_id;
    logic [1:0]      cmpl_valid;
    logic [2*IDW-1:0] cmpl_id;
    logic            flush;
    logic [3:0]      bank_w_en;
    logic [3:0]      bank_r_en;
    logic            bank_clr;
    logic [1:0]      ret_valid;
    logic [2*IDW-1:0] ret_id;
    logic [IDW:0]    rob_count;

    int n_chk  = 0;
    int n_fail = 0;

    rob_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .disp_id    (disp_id),
        .cmpl_valid (cmpl_valid),
        .cmpl_id    (cmpl_id),
        .flush      (flush),
        .bank_w_en  (bank_w_en),
        .bank_r_en  (bank_r_en),
        .bank_clr   (bank_clr),
        .ret_valid  (ret_valid),
        .ret_id     (ret_id),
        .rob_count  (rob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Two packed lane IDs: lane1 in the upper IDW bits.
    function automatic logic [31:0] pair(input int hi, input int lo);
        pair = (32'(hi) << IDW) | 32'(lo);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; disp_valid = 2'b00; cmpl_valid = 2'b00; cmpl_id = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        sample();
        check_eq("rst_count", 32'(rob_count), 32'd0);
        check_eq("rst_ret_valid", 32'(ret_valid), 32'd0);
        check_eq("rst_ready", 32'(disp_ready), 32'd3);
        check_eq("rst_disp_id", 32'(disp_id), pair(1, 0));
        check_eq("rst_bank_clr", 32'(bank_clr), 32'd0);
        check_eq("rst_w_en", 32'(bank_w_en), 32'd0);

        // Lane1 without lane0 is ignored.
        step(); disp_valid = 2'b10; sample();
        check_eq("lane1_only_w_en", 32'(bank_w_en), 32'd0);
        step(); disp_valid = 2'b00; sample();
        check_eq("lane1_only_count", 32'(rob_count), 32'd0);

        // Fill: two per cycle, IDs 0..31.
        for (int c = 0; c < 16; c++) begin
            step(); disp_valid = 2'b11; sample();
            check_eq("fill_id", 32'(disp_id), pair(2*c+1, 2*c));
            check_eq("fill_w_en", 32'(bank_w_en), (c % 2 == 1) ? 32'd12 : 32'd3);
            if (c == 1) check_eq("fill_count_lat", 32'(rob_count), 32'd2);
        end
        step(); disp_valid = 2'b11; sample();
        check_eq("full_ready", 32'(disp_ready), 32'd0);
        check_eq("full_count", 32'(rob_count), 32'd32);
        check_eq("full_w_en", 32'(bank_w_en), 32'd0);

        // Out-of-order completion 3,1,2,0.
        disp_valid = 2'b00;
        for (int j = 0; j < 4; j++) begin
            step(); cmpl_valid = 2'b01;
            cmpl_id = 10'(pair(0, (j == 0) ? 3 : (j == 1) ? 1 : (j == 2) ? 2 : 0));
            sample();
            check_eq("ooo_no_retire", 32'(ret_valid), 32'd0);
        end
        step(); cmpl_valid = 2'b00; disp_valid = 2'b11; sample();
        check_eq("ooo_ret01_valid", 32'(ret_valid), 32'd3);
        check_eq("ooo_ret01_id", 32'(ret_id), pair(1, 0));
        check_eq("ooo_ret01_r_en", 32'(bank_r_en), 32'd3);
        check_eq("full_retire_ready", 32'(disp_ready), 32'd0);
        check_eq("full_retire_w_en", 32'(bank_w_en), 32'd0);
        step(); disp_valid = 2'b00; sample();
        check_eq("ooo_ret23_valid", 32'(ret_valid), 32'd3);
        check_eq("ooo_ret23_id", 32'(ret_id), pair(3, 2));
        check_eq("ooo_ret23_r_en", 32'(bank_r_en), 32'd12);
        check_eq("ooo_count30", 32'(rob_count), 32'd30);
        step(); disp_valid = 2'b11; sample();
        check_eq("wrap_count28", 32'(rob_count), 32'd28);
        check_eq("wrap_disp_id", 32'(disp_id), pair(1, 0));
        check_eq("wrap_w_en", 32'(bank_w_en), 32'd3);

        // Complete 4..29 and let them drain to head=30.
        for (int k = 0; k < 13; k++) begin
            step(); disp_valid = 2'b00; cmpl_valid = 2'b11;
            cmpl_id = 10'(pair(5 + 2*k, 4 + 2*k));
        end
        step(); cmpl_valid = 2'b00;
        step(); cmpl_valid = 2'b11; cmpl_id = 10'(pair(31, 30)); sample();
        check_eq("wrap_head30_idle", 32'(ret_valid), 32'd0);
        check_eq("wrap_count4", 32'(rob_count), 32'd4);
        step(); cmpl_id = 10'(pair(1, 0)); sample();
        check_eq("wrap_ret3031_valid", 32'(ret_valid), 32'd3);
        check_eq("wrap_ret3031_id", 32'(ret_id), pair(31, 30));
        check_eq("wrap_ret3031_r_en", 32'(bank_r_en), 32'd12);
        step(); cmpl_valid = 2'b00; sample();
        check_eq("wrap_ret01_valid", 32'(ret_valid), 32'd3);
        check_eq("wrap_ret01_id", 32'(ret_id), pair(1, 0));
        check_eq("wrap_ret01_r_en", 32'(bank_r_en), 32'd3);
        step(); sample();
        check_eq("wrap_empty_count", 32'(rob_count), 32'd0);
        check_eq("wrap_empty_ret", 32'(ret_valid), 32'd0);
        check_eq("wrap_next_id", 32'(disp_id), pair(3, 2));

        // Flush: 10 entries (IDs 2..11), half done.
        for (int c = 0; c < 5; c++) begin
            step(); disp_valid = 2'b11;
        end
        step(); disp_valid = 2'b00; cmpl_valid = 2'b11; cmpl_id = 10'(pair(5, 3));
        step(); cmpl_id = 10'(pair(9, 7));
        step(); cmpl_valid = 2'b01; cmpl_id = 10'(pair(0, 11));
        step(); cmpl_valid = 2'b01; cmpl_id = 10'(pair(0, 2)); sample();
        check_eq("pre_flush_count", 32'(rob_count), 32'd10);
        check_eq("pre_flush_ret", 32'(ret_valid), 32'd0);
        step(); cmpl_valid = 2'b00; flush = 1'b1; disp_valid = 2'b11; sample();
        check_eq("flush_ready", 32'(disp_ready), 32'd0);
        check_eq("flush_w_en", 32'(bank_w_en), 32'd0);
        check_eq("flush_ret", 32'(ret_valid), 32'd0);
        check_eq("flush_r_en", 32'(bank_r_en), 32'd0);
        step(); flush = 1'b0; disp_valid = 2'b00; sample();
        check_eq("post_flush_count", 32'(rob_count), 32'd0);
        check_eq("post_flush_clr", 32'(bank_clr), 32'd1);
        check_eq("post_flush_id", 32'(disp_id), pair(1, 0));
        check_eq("post_flush_ret", 32'(ret_valid), 32'd0);
        step(); sample();
        check_eq("clr_one_cycle", 32'(bank_clr), 32'd0);

        // Stale completion of ID 9 while 0..3 occupied.
        step(); disp_valid = 2'b11;
        step();
        step(); disp_valid = 2'b00; cmpl_valid = 2'b01; cmpl_id = 10'(pair(0, 9)); sample();
        check_eq("stale_count4", 32'(rob_count), 32'd4);
        step(); cmpl_valid = 2'b00; disp_valid = 2'b11; sample();
        check_eq("stale_no_ret", 32'(ret_valid), 32'd0);
        step();
        step(); sample();
        check_eq("stale_id89", 32'(disp_id), pair(9, 8));
        step(); disp_valid = 2'b00; cmpl_valid = 2'b11; cmpl_id = 10'(pair(1, 0));
        step(); cmpl_id = 10'(pair(3, 2)); sample();
        check_eq("stale_ret01", 32'(ret_id), pair(1, 0));
        step(); cmpl_id = 10'(pair(5, 4));
        step(); cmpl_id = 10'(pair(7, 6));
        step(); cmpl_valid = 2'b01; cmpl_id = 10'(pair(0, 8));
        step(); cmpl_valid = 2'b00;
        step(); sample();
        check_eq("stale_9_not_done", 32'(ret_valid), 32'd0);
        check_eq("stale_count1", 32'(rob_count), 32'd1);
        cmpl_valid = 2'b01; cmpl_id = 10'(pair(0, 9));
        step(); cmpl_valid = 2'b00; sample();
        check_eq("stale_ret9_valid", 32'(ret_valid), 32'd1);
        check_eq("stale_ret9_id", 32'(ret_id), pair(10, 9));
        check_eq("stale_ret9_r_en", 32'(bank_r_en), 32'd2);

        // Mid-run reset.
        step(); disp_valid = 2'b11;
        step(); rst = 1'b1;
        step(); rst = 1'b0; disp_valid = 2'b00; sample();
        check_eq("mid_rst_count", 32'(rob_count), 32'd0);
        check_eq("mid_rst_clr", 32'(bank_clr), 32'd0);
        check_eq("mid_rst_id", 32'(disp_id), pair(1, 0));
        check_eq("mid_rst_ready", 32'(disp_ready), 32'd3);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
